// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial adder controller sharing one 4-bit ripple-carry adder
// Optional feature macro: NIBBLE_SERIAL_SUB_EN (enables subtraction through the sub port).

// Plain 4-bit ripple-carry adder, the only arithmetic in the block.
module ripple_carry_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign co = c[4];

endmodule

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
);

    localparam int         W        = 4 * NIBBLES;
    localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           carry;
    logic [2:0]     idx;
    logic [W-1:0]   b_eff;
    logic           cin_eff;
    logic [3:0]     nib_a;
    logic [3:0]     nib_b;
    logic [3:0]     nib_s;
    logic           nib_co;
    logic           accept;
    logic           last;

`ifdef NIBBLE_SERIAL_SUB_EN
    // Two's-complement subtract: invert B once at capture and force carry-in high.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign cin_eff    = cin;
`endif

    assign accept = (state == IDLE) && in_valid;
    assign last   = (idx == LAST_IDX);

    // Select the current nibble of each captured operand for the shared adder.
    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == 3'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    ripple_carry_adder_4bit u_adder (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry),
        .s  (nib_s),
        .co (nib_co)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs; DONE always returns through IDLE before the next accept.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture and one nibble of addition per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= 3'd0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b_eff;
            carry <= cin_eff;
            idx   <= 3'd0;
        end else if (state == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx == 3'(i)) begin
                    sum[4*i +: 4] <= nib_s;
                end
            end
            carry <= nib_co;
            idx   <= idx + 3'd1;
            if (last) begin
                cout <= nib_co;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed scoreboard bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int           compared   = 0;
    int           mismatched = 0;
    int           cyc        = 0;
    int           acc_cyc    = 0;
    int           last_acc   = 0;
    int           n_acc      = 0;
    bit           have_acc   = 0;
    bit           chk_space  = 0;
    bit           accepted   = 0;
    logic         prev_ov    = 0;
    logic [W:0]   exp_q[$];

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv, input logic sv);
        logic [W-1:0] be;
        logic         ce;
        be = bv;
        ce = cv;
`ifdef NIBBLE_SERIAL_SUB_EN
        if (sv) begin
            be = ~bv;
            ce = 1'b1;
        end
`else
        if (sv) begin
            be = bv;
        end
`endif
        return {1'b0, av} + {1'b0, be} + {{W{1'b0}}, ce};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the handshake that completes on this edge, then sample #1 after it.
    task automatic tick();
        logic         acc_now;
        logic         xfer_now;
        logic [W:0]   res_now;
        logic [W:0]   exp_now;
        acc_now  = in_ready & in_valid;
        xfer_now = out_valid & out_ready;
        res_now  = {cout, sum};
        exp_now  = model(a, b, cin, sub);
        accepted = 1'b0;
        if (xfer_now) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(res_now), 64'hDEAD);
            end else begin
                check("result", 64'(res_now), 64'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        cyc++;
        if (acc_now) begin
            exp_q.push_back(exp_now);
            accepted = 1'b1;
            if (chk_space && have_acc) begin
                check("accept_spacing", 64'(cyc - last_acc), 64'(N + 2));
            end
            have_acc = 1'b1;
            last_acc = cyc;
            acc_cyc  = cyc;
            n_acc++;
        end
        #1;
        if (out_valid && !prev_ov) begin
            check("latency", 64'(cyc - acc_cyc), 64'(N));
        end
        prev_ov = out_valid;
    endtask

    task automatic issue(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic sv);
        a        = av;
        b        = bv;
        cin      = cv;
        sub      = sv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_accepted"}, 64'(accepted), 64'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'({in_ready, out_valid, cout, sum}), 64'({1'b1, 1'b0, 1'b0, 16'h0000}));
        rst_n = 1'b1;
        tick();

        // Basic add with the consumer always ready.
        out_ready = 1'b1;
        issue("add_1234", 16'h1234, 16'h1111, 1'b0, 1'b0);
        drain("add_1234");
        check("add_1234_ov_low", 64'(out_valid), 64'd0);
        check("add_1234_sum", 64'({cout, sum}), 64'({1'b0, 16'h2345}));

        // Carry rippling through every nibble.
        issue("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        drain("ripple");
        check("ripple_sum", 64'({cout, sum}), 64'({1'b1, 16'h0000}));

        // Back-pressure: result must hold while out_ready is low.
        tick();
        out_ready = 1'b0;
        issue("hold", 16'h00FF, 16'h0000, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("hold_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_stable", 64'({in_ready, out_valid, cout, sum}),
                  64'({1'b0, 1'b1, 1'b0, 16'h0100}));
        end
        out_ready = 1'b1;
        tick();
        check("hold_back_idle", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
        check("hold_scored", 64'(exp_q.size()), 64'd0);

        // Reset in the second RUN cycle aborts the transaction.
        tick();
        issue("abort", 16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_reset_outputs", 64'({in_ready, out_valid, cout, sum}),
              64'({1'b1, 1'b0, 1'b0, 16'h0000}));
        exp_q.delete();
        prev_ov = 1'b0;
        #2;
        rst_n = 1'b1;
        issue("after_reset", 16'h0001, 16'h0001, 1'b0, 1'b0);
        drain("after_reset");
        check("after_reset_sum", 64'({cout, sum}), 64'({1'b0, 16'h0002}));

        // Subtract (or sub ignored in the default build).
        tick();
`ifdef NIBBLE_SERIAL_SUB_EN
        issue("sub_nb", 16'h1000, 16'h0001, 1'b0, 1'b1);
        drain("sub_nb");
        check("sub_nb_sum", 64'({cout, sum}), 64'({1'b1, 16'h0FFF}));
        tick();
        issue("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1);
        drain("sub_borrow");
        check("sub_borrow_sum", 64'({cout, sum}), 64'({1'b0, 16'hFFFF}));
`else
        issue("sub_ignored", 16'h1000, 16'h0001, 1'b0, 1'b1);
        drain("sub_ignored");
        check("sub_ignored_sum", 64'({cout, sum}), 64'({1'b0, 16'h1001}));
`endif
        sub = 1'b0;
        tick();

        // in_valid held high with operands toggling every cycle.
        chk_space = 1'b1;
        have_acc  = 1'b0;
        n_acc     = 0;
        in_valid  = 1'b1;
        n = 0;
        while (n_acc < 4 && n < 60) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            tick();
            n++;
        end
        check("stream_accepts", 64'(n_acc), 64'd4);
        in_valid  = 1'b0;
        chk_space = 1'b0;
        drain("stream");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
